// File: rtl/kd_tree_root_ctrl_if.sv
// Command/data bus between the kd-tree root controller and the root node's top port.
// master: controller side (drives the *_to_root signals).
// slave:  root node side (drives the *_from_root signals).
interface kd_tree_root_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CMD_W  = 3
);
    logic              alert_to_root;
    logic [CMD_W-1:0]  command_to_root;
    logic [DATA_W-1:0] data_to_root;
    logic              ready_from_root;
    logic              alert_from_root;
    logic [CMD_W-1:0]  command_from_root;
    logic [DATA_W-1:0] data_from_root;

    modport master (
        output alert_to_root,
        output command_to_root,
        output data_to_root,
        input  ready_from_root,
        input  alert_from_root,
        input  command_from_root,
        input  data_from_root
    );

    modport slave (
        input  alert_to_root,
        input  command_to_root,
        input  data_to_root,
        output ready_from_root,
        output alert_from_root,
        output command_from_root,
        output data_from_root
    );
endinterface

// File: rtl/kd_tree_root_ctrl.sv
// kd_tree_root_ctrl: host-side initiator that runs a full kd-tree sort on the root node.
// Each pass (one per tree level) sends CFG_TTL, CFG_AXIS and START_SORT strobes, then waits
// for SORT_ACK from the root. All outputs are registered.
// Optional ack watchdog: define KD_ROOT_CTRL_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog
// and an ERROR state.
module kd_tree_root_ctrl #(
    parameter int DATA_W = 16,
    parameter int CMD_W  = 3,
    parameter int DEPTH  = 4,
    parameter int DIM    = 3
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    kd_tree_root_ctrl_if.master        root_bus,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] pass_cnt,
    output logic                       proto_err
);

    localparam int PC_W = $clog2(DEPTH + 1);
    localparam int AX_W = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [CMD_W-1:0] CMD_NOP        = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_CFG_TTL    = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_CFG_AXIS   = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_START_SORT = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_SORT_ACK   = CMD_W'(4);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND_TTL   = 3'd1,
        S_SEND_AXIS  = 3'd2,
        S_SEND_START = 3'd3,
        S_WAIT_ACK   = 3'd4,
        S_NEXT       = 3'd5,
        S_DONE       = 3'd6
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
        ,
        S_ERROR      = 3'd7
`endif
    } state_t;

    state_t             state_r, state_nx_s;
    logic [PC_W-1:0]    pass_cnt_r, pass_cnt_nx_s;
    logic [AX_W-1:0]    axis_r, axis_nx_s;
    logic               busy_r, busy_nx_s;
    logic               done_r, done_nx_s;
    logic               proto_err_r, proto_err_nx_s;
    logic               alert_r, alert_nx_s;
    logic [CMD_W-1:0]   cmd_r, cmd_nx_s;
    logic [DATA_W-1:0]  data_r, data_nx_s;
    logic               launch_s;
    logic               ack_s;
    logic               unexpected_s;
    logic               to_err_s;
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_r, wd_nx_s;
`endif

    // The root's payload carries nothing this controller needs; fold it into a sink.
    logic unused_data_s;
    assign unused_data_s = ^root_bus.data_from_root;

    // Classify the root's return traffic: a valid ack, or anything else that is a protocol error.
    always_comb begin
        ack_s        = 1'b0;
        unexpected_s = 1'b0;
        if (root_bus.alert_from_root) begin
            if ((state_r == S_WAIT_ACK) && (root_bus.command_from_root == CMD_SORT_ACK)) begin
                ack_s = 1'b1;
            end else begin
                unexpected_s = 1'b1;
            end
        end else begin
            ack_s        = 1'b0;
            unexpected_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and next values of every registered output and counter.
    always_comb begin
        state_nx_s    = state_r;
        pass_cnt_nx_s = pass_cnt_r;
        axis_nx_s     = axis_r;
        busy_nx_s     = busy_r;
        done_nx_s     = 1'b0;
        alert_nx_s    = 1'b0;
        cmd_nx_s      = CMD_NOP;
        data_nx_s     = {DATA_W{1'b0}};
        launch_s      = 1'b0;
        to_err_s      = 1'b0;
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
        wd_nx_s       = wd_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    launch_s = 1'b1;
                end else begin
                    launch_s = 1'b0;
                end
            end
            S_SEND_TTL: begin
                if (root_bus.ready_from_root) begin
                    alert_nx_s = 1'b1;
                    cmd_nx_s   = CMD_CFG_TTL;
                    data_nx_s  = DATA_W'(DEPTH - 1) - DATA_W'(pass_cnt_r);
                    state_nx_s = S_SEND_AXIS;
                end else begin
                    state_nx_s = S_SEND_TTL;
                end
            end
            S_SEND_AXIS: begin
                if (root_bus.ready_from_root) begin
                    alert_nx_s = 1'b1;
                    cmd_nx_s   = CMD_CFG_AXIS;
                    data_nx_s  = DATA_W'(axis_r);
                    state_nx_s = S_SEND_START;
                end else begin
                    state_nx_s = S_SEND_AXIS;
                end
            end
            S_SEND_START: begin
                if (root_bus.ready_from_root) begin
                    alert_nx_s = 1'b1;
                    cmd_nx_s   = CMD_START_SORT;
                    data_nx_s  = {DATA_W{1'b0}};
                    state_nx_s = S_WAIT_ACK;
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
                    wd_nx_s    = {WD_W{1'b0}};
`endif
                end else begin
                    state_nx_s = S_SEND_START;
                end
            end
            S_WAIT_ACK: begin
                if (ack_s) begin
                    state_nx_s = S_NEXT;
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
                end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // The watchdog expires in the cycle it reaches TIMEOUT_CYCLES waits.
                    state_nx_s = S_ERROR;
                    busy_nx_s  = 1'b0;
                    to_err_s   = 1'b1;
                end else begin
                    wd_nx_s    = wd_r + WD_W'(1);
`else
                end else begin
                    state_nx_s = S_WAIT_ACK;
`endif
                end
            end
            S_NEXT: begin
                pass_cnt_nx_s = pass_cnt_r + PC_W'(1);
                if (axis_r == AX_W'(DIM - 1)) begin
                    axis_nx_s = {AX_W{1'b0}};
                end else begin
                    axis_nx_s = axis_r + AX_W'(1);
                end
                if ((pass_cnt_r + PC_W'(1)) == PC_W'(DEPTH)) begin
                    state_nx_s = S_DONE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = S_SEND_TTL;
                end
            end
            S_DONE: begin
                busy_nx_s  = 1'b0;
                state_nx_s = S_IDLE;
            end
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
            S_ERROR: begin
                if (start) begin
                    launch_s = 1'b1;
                end else begin
                    state_nx_s = S_ERROR;
                end
            end
`endif
            default: begin
                state_nx_s = S_IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase

        if (launch_s) begin
            state_nx_s    = S_SEND_TTL;
            pass_cnt_nx_s = {PC_W{1'b0}};
            axis_nx_s     = {AX_W{1'b0}};
            busy_nx_s     = 1'b1;
        end else begin
            busy_nx_s     = busy_nx_s;
        end

        // An accepted start clears the sticky error; otherwise errors accumulate.
        if (launch_s) begin
            proto_err_nx_s = 1'b0;
        end else if (unexpected_s || to_err_s) begin
            proto_err_nx_s = 1'b1;
        end else begin
            proto_err_nx_s = proto_err_r;
        end
    end

    // Datapath and output registers; reset drops any in-flight strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt_r  <= {PC_W{1'b0}};
            axis_r      <= {AX_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            proto_err_r <= 1'b0;
            alert_r     <= 1'b0;
            cmd_r       <= CMD_NOP;
            data_r      <= {DATA_W{1'b0}};
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
            wd_r        <= {WD_W{1'b0}};
`endif
        end else begin
            pass_cnt_r  <= pass_cnt_nx_s;
            axis_r      <= axis_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            proto_err_r <= proto_err_nx_s;
            alert_r     <= alert_nx_s;
            cmd_r       <= cmd_nx_s;
            data_r      <= data_nx_s;
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
            wd_r        <= wd_nx_s;
`endif
        end
    end

    assign root_bus.alert_to_root   = alert_r;
    assign root_bus.command_to_root = cmd_r;
    assign root_bus.data_to_root    = data_r;
    assign busy                     = busy_r;
    assign done                     = done_r;
    assign pass_cnt                 = pass_cnt_r;
    assign proto_err                = proto_err_r;

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// Directed self-checking bench for kd_tree_root_ctrl (DEPTH=4, DIM=3).
// Expected TTL sequence per run: 3,2,1,0; axis sequence: 0,1,2,0.
module tb_kd_tree_root_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] pass_cnt;
    logic       proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int done_cnt   = 0;

    kd_tree_root_ctrl_if #(.DATA_W(16), .CMD_W(3)) bus ();

    kd_tree_root_ctrl #(
        .DATA_W(16),
        .CMD_W(3),
        .DEPTH(4),
        .DIM(3)
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .root_bus (bus.master),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt),
        .proto_err(proto_err)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (rst && bus.alert_to_root) strobe_cnt <= strobe_cnt + 1;
        if (rst && done) done_cnt <= done_cnt + 1;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_alert(input logic [2:0] cmd);
        bus.alert_from_root   = 1'b1;
        bus.command_from_root = cmd;
        tick();
        bus.alert_from_root   = 1'b0;
        bus.command_from_root = 3'd0;
    endtask

    task automatic expect_strobe(input string tag, input logic [2:0] cmd, input logic [15:0] dat,
                                 input int max_cyc);
        int waited;
        waited = 0;
        while (waited < max_cyc) begin
            tick();
            waited++;
            if (bus.alert_to_root) break;
        end
        check_eq({tag, "_alert"}, {31'd0, bus.alert_to_root}, 32'd1);
        check_eq({tag, "_cmd"},   {29'd0, bus.command_to_root}, {29'd0, cmd});
        check_eq({tag, "_data"},  {16'd0, bus.data_to_root}, {16'd0, dat});
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("launch_busy", {31'd0, busy}, 32'd1);
        check_eq("launch_pass", {29'd0, pass_cnt}, 32'd0);
        check_eq("launch_perr", {31'd0, proto_err}, 32'd0);
    endtask

    // One full pass: TTL, AXIS, START strobes, optional mid-run start pulse, ack after gap cycles.
    task automatic run_pass(input int p, input int gap, input int ttl_max, input bit mid_start);
        logic [15:0] ttl_exp;
        logic [15:0] ax_exp;
        ttl_exp = 16'(3 - p);
        ax_exp  = 16'(p % 3);
        expect_strobe("ttl", 3'd1, ttl_exp, ttl_max);
        check_eq("pass_cnt", {29'd0, pass_cnt}, 32'(p));
        expect_strobe("axis", 3'd2, ax_exp, 1);
        expect_strobe("start", 3'd3, 16'd0, 1);
        if (mid_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check_eq("midstart_pass", {29'd0, pass_cnt}, 32'(p));
            check_eq("midstart_busy", {31'd0, busy}, 32'd1);
        end
        repeat (gap) tick();
        send_alert(3'd4);
    endtask

    task automatic finish_run();
        tick();
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("done_busy",  {31'd0, busy}, 32'd1);
        check_eq("done_pass",  {29'd0, pass_cnt}, 32'd4);
        tick();
        check_eq("after_done", {31'd0, done}, 32'd0);
        check_eq("after_busy", {31'd0, busy}, 32'd0);
        check_eq("after_pass", {29'd0, pass_cnt}, 32'd4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_alert"}, {31'd0, bus.alert_to_root}, 32'd0);
        check_eq({tag, "_cmd"},   {29'd0, bus.command_to_root}, 32'd0);
        check_eq({tag, "_data"},  {16'd0, bus.data_to_root}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
        check_eq({tag, "_pass"},  {29'd0, pass_cnt}, 32'd0);
        check_eq({tag, "_perr"},  {31'd0, proto_err}, 32'd0);
    endtask

    initial begin
        int s_base;
        int d_base;
        rst                   = 1'b0;
        start                 = 1'b0;
        bus.ready_from_root   = 1'b1;
        bus.alert_from_root   = 1'b0;
        bus.command_from_root = 3'd0;
        bus.data_from_root    = 16'h5A5A;
        repeat (3) tick();
        check_reset_outputs("reset");
        #2 rst = 1'b1;
        tick();

        // Nominal run, ack two cycles after each START_SORT.
        s_base = strobe_cnt;
        d_base = done_cnt;
        launch();
        run_pass(0, 2, 1, 1'b0);
        for (int p = 1; p < 4; p++) run_pass(p, 2, 2, 1'b0);
        finish_run();
        check_eq("strobe_total", 32'(strobe_cnt - s_base), 32'd12);
        check_eq("done_total",   32'(done_cnt - d_base), 32'd1);

        // Alert while idle is a protocol error; state stays idle.
        send_alert(3'd4);
        check_eq("idle_alert_perr", {31'd0, proto_err}, 32'd1);
        check_eq("idle_alert_busy", {31'd0, busy}, 32'd0);

        // Backpressure at SEND_AXIS of pass 1.
        launch();
        run_pass(0, 2, 1, 1'b0);
        expect_strobe("bp_ttl", 3'd1, 16'd2, 2);
        bus.ready_from_root = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_no_strobe", {31'd0, bus.alert_to_root}, 32'd0);
        end
        bus.ready_from_root = 1'b1;
        expect_strobe("bp_axis", 3'd2, 16'd1, 1);
        expect_strobe("bp_start", 3'd3, 16'd0, 1);
        repeat (2) tick();
        send_alert(3'd4);
        run_pass(2, 2, 2, 1'b0);
        run_pass(3, 2, 2, 1'b0);
        finish_run();

        // Ack in first WAIT_ACK cycle; start pulsed mid-run is ignored.
        launch();
        run_pass(0, 0, 1, 1'b0);
        run_pass(1, 0, 2, 1'b1);
        run_pass(2, 0, 2, 1'b0);
        run_pass(3, 0, 2, 1'b0);
        finish_run();

        // Unexpected command 5 during WAIT_ACK, then reset mid-WAIT_ACK of pass 2.
        launch();
        expect_strobe("pe_ttl", 3'd1, 16'd3, 1);
        expect_strobe("pe_axis", 3'd2, 16'd0, 1);
        expect_strobe("pe_start", 3'd3, 16'd0, 1);
        send_alert(3'd5);
        check_eq("pe_perr", {31'd0, proto_err}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("pe_hold_alert", {31'd0, bus.alert_to_root}, 32'd0);
            check_eq("pe_hold_pass", {29'd0, pass_cnt}, 32'd0);
        end
        send_alert(3'd4);
        run_pass(1, 2, 2, 1'b0);
        check_eq("pe_sticky", {31'd0, proto_err}, 32'd1);
        expect_strobe("rs_ttl", 3'd1, 16'd1, 2);
        expect_strobe("rs_axis", 3'd2, 16'd2, 1);
        expect_strobe("rs_start", 3'd3, 16'd0, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #2 rst = 1'b1;
        tick();
        check_eq("midrst_idle_busy", {31'd0, busy}, 32'd0);

        // Rerun after reset starts from pass 0 with TTL=3.
        launch();
        run_pass(0, 2, 1, 1'b0);
        for (int p = 1; p < 4; p++) run_pass(p, 2, 2, 1'b0);
        finish_run();

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
        // No ack: ERROR 16 cycles after WAIT_ACK entry.
        launch();
        expect_strobe("to_ttl", 3'd1, 16'd3, 1);
        expect_strobe("to_axis", 3'd2, 16'd0, 1);
        expect_strobe("to_start", 3'd3, 16'd0, 1);
        repeat (15) tick();
        check_eq("to_pre_busy", {31'd0, busy}, 32'd1);
        check_eq("to_pre_perr", {31'd0, proto_err}, 32'd0);
        tick();
        check_eq("to_err_busy", {31'd0, busy}, 32'd0);
        check_eq("to_err_perr", {31'd0, proto_err}, 32'd1);
        repeat (3) tick();
        check_eq("to_hold_perr", {31'd0, proto_err}, 32'd1);
        launch();
        expect_strobe("to_relaunch_ttl", 3'd1, 16'd3, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kd_tree_root_ctrl.md
Name: kd_tree_root_ctrl

Overview:
- Host-side initiator for the kd-tree node command protocol; drives the top port of the root node.
- Runs one complete tree sort as a sequence of passes, one pass per tree level.
- Each pass sends time_to_live, then sorting axis, then start_sort, then waits for the sort acknowledge returned by the root.
- Sits between the k-means top-level sequencer and the root node instance of the kd-tree.

Parameters:
- DATA_W, 16, width of the data bus to/from the root node.
- CMD_W, 3, width of the command bus.
- DEPTH, 4, number of tree levels, which equals the number of passes; 1..2^DATA_W-1.
- DIM, 3, number of point dimensions; axis cycles 0..DIM-1.
- TIMEOUT_CYCLES, 1024, ack watchdog limit (only when TIMEOUT_EN is defined).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse that begins a sort; honoured only in IDLE.
- ready_from_root  in  1  root can accept a command this cycle.
- alert_from_root  in  1  command_from_root/data_from_root valid this cycle.
- command_from_root  in  CMD_W  command returned by the root.
- data_from_root  in  DATA_W  payload returned by the root; ignored by this block.
- alert_to_root  out  1  one-cycle strobe; command_to_root/data_to_root valid.
- command_to_root  out  CMD_W  command to the root.
- data_to_root  out  DATA_W  payload to the root.
- busy  out  1  high from start acceptance until DONE is left.
- done  out  1  one-cycle pulse when the final ack has been received.
- pass_cnt  out  clog2(DEPTH+1)  index of the current pass.
- proto_err  out  1  sticky flag for an unexpected command; cleared on an accepted start.

Behaviour:
- Command codes:
  - CMD_NOP=0, CMD_CFG_TTL=1, CMD_CFG_AXIS=2, CMD_START_SORT=3, CMD_SORT_ACK=4.
  - Codes 5 and 6 (switch_with_top, switch_with_down) are node-to-node only and are never issued by this block.
- Reset values of all outputs: alert_to_root=0, command_to_root=CMD_NOP, data_to_root=0, busy=0, done=0, pass_cnt=0, proto_err=0. Reset also forces the state to IDLE.
- States: IDLE, SEND_TTL, SEND_AXIS, SEND_START, WAIT_ACK, NEXT, DONE (plus ERROR with TIMEOUT_EN).
- IDLE, start=1: pass_cnt<=0, axis<=0, proto_err<=0, busy<=1, go to SEND_TTL.
- Send states (SEND_TTL, SEND_AXIS, SEND_START):
  - Issue only in a cycle with ready_from_root=1.
  - The registered outputs drive alert_to_root=1 for exactly one cycle, with the command and data for that state.
  - Then advance to the next state.
  - While ready_from_root=0, hold the state with alert_to_root=0.
- Payloads:
  - CFG_TTL: data_to_root = DEPTH-1-pass_cnt, zero-extended.
  - CFG_AXIS: data_to_root = current axis.
  - START_SORT: data_to_root = 0.
- Latency: minimum 3 cycles from entering SEND_TTL to the START_SORT strobe.
- WAIT_ACK: alert_from_root=1 with command_from_root=CMD_SORT_ACK moves to NEXT. An ack arriving in the first WAIT_ACK cycle is accepted.
- NEXT:
  - pass_cnt += 1.
  - axis = (axis==DIM-1) ? 0 : axis+1.
  - If the new pass_cnt==DEPTH, go to DONE; otherwise go to SEND_TTL.
- DONE: done=1 for one cycle, busy<=0, then IDLE. pass_cnt holds DEPTH until the next accepted start.
- Unexpected input:
  - alert_from_root with any command other than SORT_ACK, or any alert outside WAIT_ACK, sets proto_err.
  - The command is otherwise ignored and the state is unchanged.
- start while busy: ignored, no effect.
- Asynchronous reset mid-operation: immediate return to IDLE with reset output values. An in-flight strobe is dropped.

Optional Feature:
- Macro: KD_ROOT_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - On reaching TIMEOUT_CYCLES without an ack, go to ERROR.
  - ERROR drives busy=0 and proto_err=1, and holds until start re-launches the sort.
- Not defined: no counter and no ERROR state; WAIT_ACK waits indefinitely.

Test Plan:
- Nominal run, DEPTH=4, DIM=3, ready held 1, ack 2 cycles after each START_SORT.
  - TTL sequence 3,2,1,0 and axis sequence 0,1,2,0 on data_to_root.
  - 12 strobes total, one done pulse, busy deasserted the cycle after done.
- Backpressure: ready_from_root=0 for 5 cycles at SEND_AXIS of pass 1.
  - No strobe during those 5 cycles.
  - CFG_AXIS with data=1 issued on the first ready cycle; pass completes normally.
- Ack in the first WAIT_ACK cycle is accepted; start pulsed mid-run is ignored and pass_cnt is not reset.
- Root sends command 5 during WAIT_ACK: proto_err=1 and state stays WAIT_ACK; a following SORT_ACK advances to NEXT.
- rst low mid-WAIT_ACK of pass 2: all outputs return to reset values immediately; a new start reruns from pass 0 with TTL=3.
- With KD_ROOT_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack after START_SORT: ERROR entered 16 cycles after the WAIT_ACK entry, with busy=0 and proto_err=1.
